// File: rtl/clk_meter_pkg.sv
// Shared types, constants and scale helper for the clock ratio meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    WAIT_RISE = 2'd2
  } meter_state_e;

  localparam logic [7:0] SCALE_MAX = 8'd255;

  // The divider makes each half-period N+1 cycles for setting N; wider halves are out of range.
  function automatic logic [7:0] scale_from_half(input int unsigned width);
    if (width > 32'd256) return SCALE_MAX;
    else if (width == 32'd0) return 8'd0;
    else return 8'(width - 32'd1);
  endfunction

endpackage

// File: rtl/clock_ratio_meter_if.sv
// Control input, measured clock and measurement results of the clock ratio meter.
interface clock_ratio_meter_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [7:0]       scale_out;
  logic             duty_ok;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output enable, sig_in,
    input  period, high_time, low_time, scale_out, duty_ok, valid, locked, timeout
  );

  modport slave (
    input  enable, sig_in,
    output period, high_time, low_time, scale_out, duty_ok, valid, locked, timeout
  );
endinterface

// File: rtl/edge_sync.sv
// Synchroniser chain plus one history flop; emits single-cycle rise/fall pulses.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period, high and low time of an external clock in clk_in cycles,
// recovers the divider setting and tracks lock on repeated identical periods.
module clock_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 2
) (
  input  logic               clk_in,
  input  logic               rst,
  clock_ratio_meter_if.slave bus
);

  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hiCap_q, hiCap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] highTime_q, highTime_d;
  logic [CNT_W-1:0] lowTime_q, lowTime_d;
  logic [7:0]       scale_q, scale_d;
  logic             dutyOk_q, dutyOk_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [MATCH_W-1:0] match_q, match_d;

  logic             rise, fall;
  logic [CNT_W-1:0] cntInc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] periodSat;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i (clk_in),
    .rst_i (rst),
    .sig_i (bus.sig_in),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign cntInc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign sum       = {1'b0, hiCap_q} + {1'b0, cnt_q};
  assign periodSat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

  // An edge arriving on the saturated cycle is reported; only a missing edge times out.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hiCap_d    = hiCap_q;
    period_d   = period_q;
    highTime_d = highTime_q;
    lowTime_d  = lowTime_q;
    scale_d    = scale_q;
    dutyOk_d   = dutyOk_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    match_d    = match_q;

    if (!bus.enable) begin
      state_d = IDLE;
      match_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = WAIT_FALL;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_FALL: begin
          if (fall) begin
            state_d = WAIT_RISE;
            hiCap_d = cnt_q;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            match_d   = '0;
          end else begin
            cnt_d = cntInc;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d    = WAIT_FALL;
            cnt_d      = CNT_ONE;
            highTime_d = hiCap_q;
            lowTime_d  = cnt_q;
            period_d   = periodSat;
            scale_d    = scale_from_half(32'(hiCap_q));
            dutyOk_d   = (hiCap_q == cnt_q);
            valid_d    = 1'b1;
            timeout_d  = 1'b0;
            if (periodSat != period_q) match_d = MATCH_ONE;
            else if (match_q < MATCH_LOCK) match_d = match_q + MATCH_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            match_d   = '0;
          end else begin
            cnt_d = cntInc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hiCap_q    <= '0;
      period_q   <= '0;
      highTime_q <= '0;
      lowTime_q  <= '0;
      scale_q    <= '0;
      dutyOk_q   <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hiCap_q    <= hiCap_d;
      period_q   <= period_d;
      highTime_q <= highTime_d;
      lowTime_q  <= lowTime_d;
      scale_q    <= scale_d;
      dutyOk_q   <= dutyOk_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      match_q    <= match_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = highTime_q;
  assign bus.low_time  = lowTime_q;
  assign bus.scale_out = scale_q;
  assign bus.duty_ok   = dutyOk_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.locked    = (match_q >= MATCH_LOCK);

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench: drives sig_in as phase-length sequences and predicts each
// report from the phase lengths alone.
module tb_clock_ratio_meter;
  localparam int CNT_W = 10;
  localparam int LOCK  = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    int period;
    int high;
    int low;
    int scale;
    bit duty;
    bit locked;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exp_t expQ[$];
  exp_t lastExp;
  bit   armed, haveHigh, expTimeout;
  int   curHigh, curLow, prevPeriod, matchCnt;

  clock_ratio_meter_if #(.CNT_W(CNT_W)) bus ();

  clock_ratio_meter #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .LOCK_COUNT(LOCK)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void resetModel();
    expQ.delete();
    lastExp    = '{0, 0, 0, 0, 1'b0, 1'b0};
    armed      = 1'b0;
    haveHigh   = 1'b0;
    expTimeout = 1'b0;
    curHigh    = 0;
    curLow     = 0;
    prevPeriod = 0;
    matchCnt   = 0;
  endfunction

  // A complete high+low pair closed by a rise produces exactly one report.
  function automatic void pushExpected(input int h, input int l);
    exp_t e;
    int   p;
    p = (h + l > CMAX) ? CMAX : h + l;
    matchCnt   = (p == prevPeriod) ? matchCnt + 1 : 1;
    e.period   = p;
    e.high     = h;
    e.low      = l;
    e.scale    = (h > 256) ? 255 : h - 1;
    e.duty     = (h == l);
    e.locked   = (matchCnt >= LOCK);
    prevPeriod = p;
    expTimeout = 1'b0;
    lastExp    = e;
    expQ.push_back(e);
  endfunction

  task automatic stepCycle();
    exp_t e;
    @(negedge clk);
    if (bus.valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid: got valid=1 at %0t, required no pulse", $time);
      end else begin
        e = expQ.pop_front();
        if (bus.period !== CNT_W'(e.period) || bus.high_time !== CNT_W'(e.high) ||
            bus.low_time !== CNT_W'(e.low) || bus.scale_out !== 8'(e.scale) ||
            bus.duty_ok !== e.duty || bus.locked !== e.locked || bus.timeout !== 1'b0) begin
          errors++;
          $display("[TB] FAIL report at %0t: got per=%0d hi=%0d lo=%0d sc=%0d duty=%b lock=%b to=%b, required per=%0d hi=%0d lo=%0d sc=%0d duty=%b lock=%b to=0",
                   $time, bus.period, bus.high_time, bus.low_time, bus.scale_out, bus.duty_ok,
                   bus.locked, bus.timeout, e.period, e.high, e.low, e.scale, e.duty, e.locked);
        end
      end
    end
  endtask

  task automatic holdLevel(input int cycles);
    repeat (cycles) stepCycle();
  endtask

  task automatic drivePhase(input bit lvl, input int cycles);
    if (lvl && armed && haveHigh) pushExpected(curHigh, curLow);
    if (lvl) begin
      armed    = 1'b1;
      haveHigh = 1'b0;
    end
    bus.sig_in = lvl;
    holdLevel(cycles);
    if (armed) begin
      if (cycles > CMAX) begin
        armed      = 1'b0;
        haveHigh   = 1'b0;
        expTimeout = 1'b1;
        matchCnt   = 0;
      end else if (lvl) begin
        curHigh  = cycles;
        haveHigh = 1'b1;
      end else begin
        curLow = cycles;
      end
    end
  endtask

  task automatic playPeriods(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      drivePhase(1'b1, h);
      drivePhase(1'b0, l);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    resetModel();
    holdLevel(3);
    checks++;
    if ({bus.period, bus.high_time, bus.low_time} !== {3*CNT_W{1'b0}}) begin
      errors++;
      $display("[TB] FAIL reset_widths: got %0d/%0d/%0d, required 0/0/0", bus.period, bus.high_time, bus.low_time);
    end
    checks++;
    if ({bus.scale_out, bus.duty_ok, bus.valid, bus.locked, bus.timeout} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got sc=%0d duty=%b v=%b lock=%b to=%b, required all 0",
               bus.scale_out, bus.duty_ok, bus.valid, bus.locked, bus.timeout);
    end
    rst        = 1'b0;
    bus.enable = 1'b1;
    holdLevel(2);
  endtask

  task automatic test_loopback();
    drivePhase(1'b0, 4);
    playPeriods(3, 4, 4);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.period !== CNT_W'(8) || bus.scale_out !== 8'd3 || bus.duty_ok !== 1'b1 || bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loopback: got per=%0d sc=%0d duty=%b lock=%b, required per=8 sc=3 duty=1 lock=1",
               bus.period, bus.scale_out, bus.duty_ok, bus.locked);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL loopback_pending: got %0d reports outstanding, required 0", expQ.size());
    end
  endtask

  task automatic test_asym();
    drivePhase(1'b0, 9);
    playPeriods(3, 5, 9);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.period !== CNT_W'(14) || bus.high_time !== CNT_W'(5) || bus.low_time !== CNT_W'(9) ||
        bus.scale_out !== 8'd4 || bus.duty_ok !== 1'b0 || bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL asym: got per=%0d hi=%0d lo=%0d sc=%0d duty=%b lock=%b, required 14/5/9/4/0/1",
               bus.period, bus.high_time, bus.low_time, bus.scale_out, bus.duty_ok, bus.locked);
    end
  endtask

  task automatic test_scale_change();
    drivePhase(1'b0, 4);
    playPeriods(3, 4, 4);
    playPeriods(3, 11, 11);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.period !== CNT_W'(22) || bus.scale_out !== 8'd10 || bus.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL scale_change: got per=%0d sc=%0d lock=%b, required per=22 sc=10 lock=1",
               bus.period, bus.scale_out, bus.locked);
    end
  endtask

  task automatic test_reset_mid();
    drivePhase(1'b0, 6);
    rst = 1'b1;
    resetModel();
    stepCycle();
    checks++;
    if ({bus.period, bus.high_time, bus.low_time, bus.scale_out, bus.duty_ok, bus.valid, bus.locked, bus.timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got per=%0d hi=%0d lo=%0d sc=%0d lock=%b v=%b, required all 0",
               bus.period, bus.high_time, bus.low_time, bus.scale_out, bus.locked, bus.valid);
    end
    rst = 1'b0;
    holdLevel(4);
    playPeriods(2, 4, 4);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.period !== CNT_W'(8) || bus.locked !== 1'b1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_recover: got per=%0d lock=%b pending=%0d, required per=8 lock=1 pending=0",
               bus.period, bus.locked, expQ.size());
    end
  endtask

  task automatic test_timeout();
    drivePhase(1'b0, 4);
    playPeriods(2, 4, 4);
    drivePhase(1'b1, 1100);
    checks++;
    if (bus.timeout !== expTimeout || bus.locked !== 1'b0 || bus.period !== CNT_W'(lastExp.period)) begin
      errors++;
      $display("[TB] FAIL timeout_set: got to=%b lock=%b per=%0d, required to=%b lock=0 per=%0d",
               bus.timeout, bus.locked, bus.period, expTimeout, lastExp.period);
    end
    drivePhase(1'b0, 4);
    playPeriods(2, 4, 4);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.timeout !== 1'b0 || bus.period !== CNT_W'(8) || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got to=%b per=%0d pending=%0d, required to=0 per=8 pending=0",
               bus.timeout, bus.period, expQ.size());
    end
  endtask

  task automatic test_saturation();
    drivePhase(1'b0, 4);
    drivePhase(1'b1, CMAX);
    drivePhase(1'b0, CMAX);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.period !== CNT_W'(CMAX) || bus.high_time !== CNT_W'(CMAX) || bus.scale_out !== 8'hFF || bus.timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturation: got per=%0d hi=%0d sc=%0d to=%b, required per=%0d hi=%0d sc=255 to=0",
               bus.period, bus.high_time, bus.scale_out, bus.timeout, CMAX, CMAX);
    end
  endtask

  task automatic test_large_enable();
    drivePhase(1'b0, 4);
    playPeriods(2, 300, 300);
    drivePhase(1'b1, 150);
    bus.enable = 1'b0;
    armed      = 1'b0;
    haveHigh   = 1'b0;
    matchCnt   = 0;
    holdLevel(20);
    checks++;
    if (bus.period !== CNT_W'(600) || bus.high_time !== CNT_W'(300) || bus.low_time !== CNT_W'(300) ||
        bus.scale_out !== 8'hFF || bus.duty_ok !== 1'b1 || bus.locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_low_hold: got per=%0d hi=%0d lo=%0d sc=%0d duty=%b lock=%b, required 600/300/300/255/1/0",
               bus.period, bus.high_time, bus.low_time, bus.scale_out, bus.duty_ok, bus.locked);
    end
    bus.enable = 1'b1;
    holdLevel(10);
    drivePhase(1'b0, 20);
    playPeriods(2, 300, 300);
    drivePhase(1'b1, 8);
    checks++;
    if (bus.locked !== 1'b1 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL enable_relock: got lock=%b pending=%0d, required lock=1 pending=0", bus.locked, expQ.size());
    end
  endtask

  task automatic test_random();
    int h, l, n;
    drivePhase(1'b0, 4);
    for (int g = 0; g < 8; g++) begin
      h = $urandom_range(1, 40);
      l = $urandom_range(1, 40);
      n = $urandom_range(1, 3);
      playPeriods(n, h, l);
    end
    drivePhase(1'b1, 8);
    checks++;
    if (bus.locked !== (matchCnt >= LOCK) || bus.period !== CNT_W'(lastExp.period) || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_final: got lock=%b per=%0d pending=%0d, required lock=%b per=%0d pending=0",
               bus.locked, bus.period, expQ.size(), (matchCnt >= LOCK), lastExp.period);
    end
  endtask

  initial begin
    $display("[TB] clock_ratio_meter bench start");
    test_reset();
    test_loopback();
    test_asym();
    test_scale_change();
    test_reset_mid();
    test_timeout();
    test_saturation();
    test_large_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
- Receiving end of the clock divider: takes a divided clock back in and measures it in reference-clock cycles.
- Reports period, high time, low time and the recovered 8-bit scale setting.
- Sits beside the divider inside the TT top. Used for on-chip loopback self-check (divider output to meter input) and for characterising external clocks on an input pin.

Parameters:
- CNT_W, 10, width of period/high/low counters in clk_in cycles; counters saturate at 2^CNT_W-1.
- SYNC_STAGES, 2, flops in the input synchroniser on sig_in (minimum 2).
- LOCK_COUNT, 2, number of consecutive identical periods required to assert locked.

Ports:
- clk_in  in  1  reference clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  measurement enable; low forces IDLE at the next edge.
- sig_in  in  1  clock to be measured; asynchronous to clk_in.
- period  out  CNT_W  last full period (rising to rising), in clk_in cycles.
- high_time  out  CNT_W  last high phase (rising to falling), in cycles.
- low_time  out  CNT_W  last low phase (falling to rising), in cycles.
- scale_out  out  8  recovered divider setting.
- duty_ok  out  1  high_time == low_time for the last measurement.
- valid  out  1  one-cycle pulse when period/high/low/scale_out update.
- locked  out  1  LOCK_COUNT consecutive identical periods seen.
- timeout  out  1  sticky; set when a counter saturated.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0. FSM returns to IDLE. Counters and synchroniser flops are cleared.
- Synchroniser: SYNC_STAGES flops, then one history flop for edge detect.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Fixed detection latency is SYNC_STAGES+1 cycles. It applies equally to both edges, so measured widths are exact.
- Counter cnt:
  - Loaded with 1 on the cycle after a detected edge.
  - Increments by 1 each cycle; saturates at all-ones.
  - Reported width = number of clk_in cycles between the two detected edges.
- FSM states: IDLE, WAIT_FALL, WAIT_RISE.
  - IDLE: on rise -> WAIT_FALL, cnt<=1, per_acc cleared.
  - WAIT_FALL: on fall -> WAIT_RISE, hi_cap<=cnt, cnt<=1.
  - WAIT_RISE: on rise -> WAIT_FALL, cnt<=1.
    - Registers update: high_time<=hi_cap, low_time<=cnt, period<=hi_cap+cnt (saturating at CNT_W).
    - valid=1 for exactly one cycle, the cycle after the update edge.
- Measurement cadence: the first valid comes after the first complete period following IDLE; after that, one valid per period. No partial periods are reported.
- Scale recovery (divider contract: for setting N, each half-period is N+1 clk_in cycles):
  - scale_out = high_time-1, truncated to 8 bits.
  - If high_time > 256, scale_out = 8'hFF.
  - duty_ok = (high_time == low_time); updated together with valid.
- Lock:
  - match counter increments when the new period equals the previous one, and resets to 1 on mismatch.
  - locked=1 while match >= LOCK_COUNT.
  - locked is cleared on timeout, on enable low, and on rst.
- Timeout:
  - If cnt reaches all-ones in WAIT_FALL or WAIT_RISE: timeout<=1, locked<=0, FSM -> IDLE.
  - period/high/low retain their last values. No valid pulse.
  - timeout clears only on rst, or on the next valid.
- enable low:
  - FSM -> IDLE; valid is not asserted.
  - Outputs hold their values; locked is cleared.
- Simultaneous events:
  - rst has priority over everything; enable low has priority over edges.
  - rise and fall cannot coincide (single history flop).
  - Saturation and an edge in the same cycle: the edge wins and the value is reported saturated; timeout is not set.
- Glitches: a pulse shorter than one clk_in cycle may be missed; no filtering is required.

Decomposition:
- Shared package clk_meter_pkg holds:
  - FSM state typedef (IDLE, WAIT_FALL, WAIT_RISE).
  - Constant SCALE_MAX = 255.
  - Function scale_from_half(width) -> 8-bit saturated scale.
- One sub-module, edge_sync: synchroniser chain plus rise/fall pulse generation, parameterised by SYNC_STAGES.
- The top holds the FSM, counters and lock logic.

Test Plan:
- Reset mid-measurement: hold rst for 1 cycle while in WAIT_RISE -> all outputs 0 next cycle, FSM IDLE, no valid until a full new period.
- Loopback from divider with scale=3 (sig_in high 4 / low 4 cycles) -> first valid with period=8, high_time=4, low_time=4, scale_out=3, duty_ok=1; locked=1 at the second valid.
- Asymmetric input, high 5 / low 9 -> period=14, high_time=5, low_time=9, scale_out=4, duty_ok=0; locked after 2 periods.
- Scale change from 3 to 10 while locked -> next valid period=22, locked drops that cycle, re-asserts after the following identical period.
- sig_in stuck high after a rise, CNT_W=10 -> timeout=1 after 1023 cycles in WAIT_FALL, locked=0, period holds 8; timeout clears on the next valid after toggling resumes.
- Large setting: high 300 / low 300 cycles -> high_time=300, scale_out=8'hFF, period=600; enable low mid-period -> no valid, locked=0, outputs held.
